// File: rtl/mul_add_pkg.sv
// Shared definitions for the sequential shift-add multiply-accumulate block.
// Contents:
//   DEF_WIDTH   default operand width
//   DEF_CNT_W   iteration-counter width for the default operand width
//   state_t     FSM state encoding (IDLE / RUN / DONE)
//   cnt_width() counter width for an arbitrary operand width
package mul_add_pkg;

    localparam int DEF_WIDTH = 32;

    // Counter must index iterations 0..WIDTH-1; keep at least one bit for WIDTH=1.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_add_step.sv
// One radix-2 shift-add iteration of the multiply-accumulate datapath.
// Purely combinational: the top registers the result.
// Ports:
//   i_acc         running accumulator (2*WIDTH bits)
//   i_mcand       current shifted multiplicand (2*WIDTH bits)
//   i_mplier_lsb  current multiplier bit
//   o_acc_next    accumulator after this iteration
module mul_add_step
    import mul_add_pkg::*;
#(
    parameter int W2 = 2 * DEF_WIDTH
) (
    input  logic [W2-1:0] i_acc,
    input  logic [W2-1:0] i_mcand,
    input  logic          i_mplier_lsb,
    output logic [W2-1:0] o_acc_next
);

    // The accumulator is wide enough for (2^W-1)^2 + (2^W-1), so this add never wraps.
    assign o_acc_next = i_mplier_lsb ? (i_acc + i_mcand) : i_acc;

endmodule

// File: rtl/mul_add_seq.sv
// Sequential radix-2 shift-add multiply-accumulate: p = a*b + c (unsigned),
// WIDTH x WIDTH -> 2*WIDTH, one iteration per clock, fixed latency of WIDTH
// cycles from the accept edge to the done pulse.
// Optional feature macro: MUL_ADD_OVF_EN adds the ovf output, which flags a
// result that does not fit in WIDTH bits.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   start  request; accepted in IDLE or DONE, ignored while busy
//   a      multiplicand
//   b      multiplier
//   c      addend, zero-extended
//   busy   high while the operation is iterating
//   done   one-cycle pulse when p holds a new result
//   p      result, held until the next accepted operation completes
//   ovf    (MUL_ADD_OVF_EN only) upper half of p is non-zero, held with p
module mul_add_seq
    import mul_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
`ifdef MUL_ADD_OVF_EN
    ,
    output logic               ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_p;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_ovf;
    logic [2*WIDTH-1:0]   w_acc_next;

    mul_add_step #(
        .W2 (2 * WIDTH)
    ) u_step (
        .i_acc        (r_acc),
        .i_mcand      (r_mcand),
        .i_mplier_lsb (r_mplier[0]),
        .o_acc_next   (w_acc_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Aborts any operation in flight; the partial result is dropped.
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_p      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, a};
                        r_mplier <= b;
                        r_acc    <= {{WIDTH{1'b0}}, c};
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // No early exit on a zero multiplier: latency stays fixed.
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt == CNT_LAST) begin
                        r_p     <= w_acc_next;
                        r_ovf   <= |w_acc_next[2*WIDTH-1:WIDTH];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign p    = r_p;

`ifdef MUL_ADD_OVF_EN
    assign ovf = r_ovf;
`else
    // Overflow flag is computed but not exported in this build.
    logic w_ovf_unused;
    assign w_ovf_unused = r_ovf;
`endif

endmodule
